// File: rtl/fake_data_ram.sv
// fake_data_ram: single-port word RAM standing in for a bus slave.
// Every access is stretched by WAIT_CYCLES stall cycles. The access completes
// in the cycle where the wait counter reaches WAIT_CYCLES. Writes are
// byte-masked and commit at the closing edge of that completion cycle.
module fake_data_ram #(
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] wrdata,
  output logic [31:0] rddata,
  output logic        stall,
  output logic [31:0] data_w
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);
  localparam int CW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_CYCLES);

  // Word storage; the bench and loaders reach it hierarchically.
  logic [31:0] inst_ram [0:DEPTH-1];

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-3:0] idx;
  logic                 req, done;

  // Address bits above the decoded range alias. The two byte-offset bits are ignored.
  assign idx = address[ADDR_BITS-1:2];

  generate
    if (ADDR_BITS < 32) begin : g_alias
      logic unused_addr;
      assign unused_addr = ^{address[31:ADDR_BITS], address[1:0]};
    end else begin : g_noalias
      logic unused_addr;
      assign unused_addr = ^address[1:0];
    end
  endgenerate

  assign req  = read | write;
  assign done = req && (cnt_q == WMAX);

  // The master sees the stall while waiting. It sees read data only in the completion cycle.
  // A simultaneous read+write still returns the pre-write word here,
  // because the commit happens at the closing edge.
  always_comb begin
    stall  = req && !done;
    rddata = (done && read) ? inst_ram[idx] : 32'h0;
    data_w = write ? wrdata : 32'h0;
  end

  // Wait counter next state: it rolls back to 0 on completion, on idle and on an abandoned request.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || done) cnt_d = '0;
    else              cnt_d = cnt_q + 1'b1;
  end

  // Counter register. Reset only clears the counter, never the memory.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Byte-masked write commit at the closing edge of a completed write. An access cut short by reset never commits.
  always_ff @(posedge clk) begin
    if (rst && done && write) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) inst_ram[idx][8*b +: 8] <= wrdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fake_data_ram.sv
// Bench for fake_data_ram. Two instances share the same inputs: one with
// WAIT_CYCLES=1 and one with WAIT_CYCLES=0. A reference model of each slave
// (shadow memory plus elapsed-wait count) is checked on every falling edge.
// Hand-computed literal checks pin the model.
module tb_fake_data_ram;

  localparam int NW = 1 << 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] wrdata;
  logic [31:0] rd0, rd1, dw0, dw1;
  logic        st0, st1;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] mm [0:1][0:NW-1];
  int          el [0:1];

  fake_data_ram #(.ADDR_BITS(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .wrdata(wrdata), .rddata(rd0), .stall(st0), .data_w(dw0));

  fake_data_ram #(.ADDR_BITS(16), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .wrdata(wrdata), .rddata(rd1), .stall(st1), .data_w(dw1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bd(input int idx, input logic [31:0] val);
    u0.inst_ram[idx] = val;
    u1.inst_ram[idx] = val;
    mm[0][idx] = val;
    mm[1][idx] = val;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic mid;
    @(negedge clk); #1;
  endtask

  // Model: an access needs WAIT_CYCLES stalled cycles before it completes.
  // Compare against the DUT, then advance the model to the coming rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          w, ix;
      bit          rq, dn;
      logic [31:0] e_rd, e_dw, a_rd, a_dw;
      logic        a_st;
      w  = k;
      ix = int'(address[15:2]);
      rq = read || write;
      dn = rq && (el[k] == w);
      e_rd = (dn && read) ? mm[k][ix] : 32'h0;
      e_dw = write ? wrdata : 32'h0;
      a_st = (k == 0) ? st0 : st1;
      a_rd = (k == 0) ? rd0 : rd1;
      a_dw = (k == 0) ? dw0 : dw1;
      if (chk_en) begin
        chk($sformatf("model_stall_w%0d", w), {31'h0, a_st}, {31'h0, rq && !dn});
        chk($sformatf("model_rddata_w%0d", w), a_rd, e_rd);
        chk($sformatf("model_data_w_w%0d", w), a_dw, e_dw);
      end
      if (!rst || !rq) el[k] = 0;
      else if (dn) begin
        if (write)
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) mm[k][ix][8*b +: 8] = wrdata[8*b +: 8];
        el[k] = 0;
      end else el[k] = el[k] + 1;
    end
  end

  initial begin
    el[0] = 0; el[1] = 0;
    rst = 1'b0; address = '0; read = 0; write = 0; byteenable = '0; wrdata = '0;
    for (int i = 0; i < NW; i++) bd(i, 32'h0);
    bd(0, 32'hA0); bd(1, 32'hA1); bd(2, 32'hA2);
    bd(4, 32'hDEADBEEF); bd(8, 32'hAABBCCDD); bd(12, 32'h1); bd(16, 32'h55555555);

    tick; chk_en = 1'b1;
    tick;
    // request during reset: counter held at 0, so the waiting slave stalls
    read = 1; address = 32'h10;
    mid; chk("rst_req_stall", {31'h0, st1}, 32'h1);
         chk("rst_req_rd_w0", rd0, 32'hDEADBEEF);
    tick; read = 0; rst = 1'b1;
    tick;

    // backdoor read of word 4 through address 0x10
    read = 1; address = 32'h10;
    mid; chk("rd10_c0_stall", {31'h0, st1}, 32'h1);
    tick;
    mid; chk("rd10_c1_stall", {31'h0, st1}, 32'h0);
         chk("rd10_c1_data", rd1, 32'hDEADBEEF);
    tick; read = 0;
    tick;

    // byte-masked write over AABBCCDD, then read back
    write = 1; address = 32'h20; wrdata = 32'h12345678; byteenable = 4'b0011;
    tick; tick; write = 0;
    mid; chk("wr20_mem", u1.inst_ram[8], 32'hAABB5678);
    tick; read = 1; address = 32'h20;
    tick;
    mid; chk("wr20_readback", rd1, 32'hAABB5678);
    tick; read = 0;
    tick;

    // aliasing above ADDR_BITS
    read = 1; address = 32'h0001_0010;
    tick;
    mid; chk("alias_rd", rd1, 32'hDEADBEEF);
    tick; read = 0;
    tick;

    // empty byte mask is a no-op
    write = 1; address = 32'h10; wrdata = 32'h0; byteenable = 4'b0000;
    tick; tick; write = 0;
    mid; chk("be0_noop", u1.inst_ram[4], 32'hDEADBEEF);
    tick;

    // write dropped before completion leaves the word alone
    write = 1; address = 32'h10; wrdata = 32'h0; byteenable = 4'b1111;
    tick; write = 0;
    mid; chk("drop_noop", u1.inst_ram[4], 32'hDEADBEEF);
    tick;

    // reset across the stall cycles of a full write
    write = 1; address = 32'h40; wrdata = 32'hFFFFFFFF; byteenable = 4'b1111; rst = 1'b0;
    tick;
    mid; chk("rstwr_stall", {31'h0, st1}, 32'h1);
         chk("rstwr_mem_w1", u1.inst_ram[16], 32'h55555555);
         chk("rstwr_mem_w0", u0.inst_ram[16], 32'h55555555);
    tick; rst = 1'b1;
    mid; chk("rstwr_restart", {31'h0, st1}, 32'h1);
    tick;
    mid; chk("rstwr_complete", {31'h0, st1}, 32'h0);
    tick; write = 0;
    mid; chk("rstwr_mem_after", u1.inst_ram[16], 32'hFFFFFFFF);
    tick;

    // read+write together: old word visible, new word committed
    read = 1; write = 1; address = 32'h30; wrdata = 32'h2; byteenable = 4'b1111;
    tick;
    mid; chk("rw_old_data", rd1, 32'h1);
    tick; read = 0; write = 0;
    mid; chk("rw_new_word", u1.inst_ram[12], 32'h2);
    tick;

    // zero-wait slave: back-to-back reads complete every cycle
    read = 1; address = 32'h0;
    mid; chk("w0_rd0_stall", {31'h0, st0}, 32'h0); chk("w0_rd0", rd0, 32'hA0);
    tick; address = 32'h4;
    mid; chk("w0_rd4_stall", {31'h0, st0}, 32'h0); chk("w0_rd4", rd0, 32'hA1);
    tick; address = 32'h8;
    mid; chk("w0_rd8_stall", {31'h0, st0}, 32'h0); chk("w0_rd8", rd0, 32'hA2);
    tick; read = 0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
